fetch_ctrl: RTL and testbench

Sequencing controller for the instruction fetch unit. It drives the fetch datapath's PC write enable and `branch`/`jmp` next-PC selects, runs the request/acknowledge handshake with instruction memory, and holds each fetched instruction until decode accepts it. Redirects are held until the fetch in flight completes. A memory timeout is reported as a sticky error.

---
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Purpose : request/acknowledge handshake between the fetch controller and
//           instruction memory.
// Signals :
//   imem_req    fetch controller -> memory, request held until acknowledged
//   imem_ack    memory -> fetch controller, imem_rdata valid this cycle
//   imem_rdata  memory -> fetch controller, 32-bit instruction word
// Modports: master (fetch controller side), slave (memory side)
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Purpose : sequencing controller for the instruction fetch unit. Issues
//           memory requests, holds each fetched word until decode accepts
//           it, steers the PC (PC+4 / branch / jump) and flags a sticky
//           error when memory fails to answer within TIMEOUT cycles.
// Ports   :
//   clk         clock, rising edge
//   reset       asynchronous, active-low
//   start       begin fetching from IDLE
//   stall       decode cannot accept inst this cycle
//   br_taken    branch redirect pulse
//   jmp_req     jump redirect pulse
//   imem        instruction memory handshake (fetch_ctrl_if.master)
//   pc_wr_en    PC write enable (combinational)
//   branch      select branch target into PC (combinational)
//   jmp         select jump target into PC (combinational)
//   inst        held instruction word (registered)
//   inst_valid  inst valid for decode
//   fetch_err   sticky memory timeout flag
//   busy        high in REQ or HOLD
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stall,
    input  logic                br_taken,
    input  logic                jmp_req,
    fetch_ctrl_if.master        imem,
    output logic                pc_wr_en,
    output logic                branch,
    output logic                jmp,
    output logic [31:0]         inst,
    output logic                inst_valid,
    output logic                fetch_err,
    output logic                busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_ERR
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pend_br;
    logic             r_pend_jmp;
    logic [31:0]      r_inst;
    logic             r_inst_valid;
    logic             r_imem_req;
    logic             r_busy;
    logic             r_fetch_err;

    // Effective redirect once this cycle's pulses are folded into the
    // pending flags: a new pulse overrides whatever was pending, and
    // br_taken beats jmp_req. These double as the next pending values.
    logic w_sel_br;
    logic w_sel_jmp;
    logic w_redir_any;
    logic w_new_redir;

    assign w_sel_br    = br_taken | (!jmp_req & r_pend_br);
    assign w_sel_jmp   = !br_taken & (jmp_req | (!r_pend_br & r_pend_jmp));
    assign w_redir_any = w_sel_br | w_sel_jmp;
    assign w_new_redir = br_taken | jmp_req;

    // PC steering is combinational so the PC writes on the edge that ends
    // the ack or redirect cycle.
    always_comb begin
        pc_wr_en = 1'b0;
        branch   = 1'b0;
        jmp      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem.imem_ack) begin
                    pc_wr_en = 1'b1;
                    branch   = w_sel_br;
                    jmp      = w_sel_jmp;
                end
            end
            S_HOLD: begin
                if (w_new_redir) begin
                    pc_wr_en = 1'b1;
                    branch   = br_taken;
                    jmp      = !br_taken;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_pend_br    <= 1'b0;
            r_pend_jmp   <= 1'b0;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_imem_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pend_br  <= w_sel_br;
                    r_pend_jmp <= w_sel_jmp;
                    if (start) begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem.imem_ack) begin
                        r_cnt      <= '0;
                        r_pend_br  <= 1'b0;
                        r_pend_jmp <= 1'b0;
                        // A redirect discards the returned word and
                        // re-requests from the new PC without leaving REQ.
                        if (!w_redir_any) begin
                            r_inst       <= imem.imem_rdata;
                            r_inst_valid <= 1'b1;
                            r_imem_req   <= 1'b0;
                            r_state      <= S_HOLD;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        // TIMEOUT-th unanswered request cycle ends here.
                        r_cnt       <= '0;
                        r_pend_br   <= 1'b0;
                        r_pend_jmp  <= 1'b0;
                        r_inst      <= '0;
                        r_imem_req  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_state     <= S_ERR;
                    end else begin
                        r_cnt      <= r_cnt + CNT_W'(1);
                        r_pend_br  <= w_sel_br;
                        r_pend_jmp <= w_sel_jmp;
                    end
                end
                S_HOLD: begin
                    // Accept or redirect (the latter flushes inst_valid).
                    if (w_new_redir || !stall) begin
                        r_inst_valid <= 1'b0;
                        r_imem_req   <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem.imem_req = r_imem_req;
    assign inst          = r_inst;
    assign inst_valid    = r_inst_valid;
    assign busy          = r_busy;
    assign fetch_err     = r_fetch_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Purpose : self-checking bench for fetch_ctrl. A table of per-cycle input
//           and expected-output records walks through fetch, stall, and
//           redirect cases; hand-written sequences cover async reset and
//           the memory timeout.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        br_taken;
    logic        jmp_req;
    logic        pc_wr_en;
    logic        branch;
    logic        jmp;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic        busy;

    int total;
    int bad;

    fetch_ctrl_if u_if ();

    fetch_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .br_taken   (br_taken),
        .jmp_req    (jmp_req),
        .imem       (u_if.master),
        .pc_wr_en   (pc_wr_en),
        .branch     (branch),
        .jmp        (jmp),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        sl;
        logic        br;
        logic        jp;
        logic        ak;
        logic [31:0] rd;
        logic        pw;
        logic        bs;
        logic        js;
        logic        rq;
        logic        iv;
        logic        by;
        logic        fe;
        logic [31:0] in;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    localparam logic [31:0] A = 32'h8C22_0004;
    localparam logic [31:0] B = 32'h1111_1111;
    localparam logic [31:0] C = 32'hDEAD_BEEF;
    localparam logic [31:0] D = 32'h2222_2222;
    localparam logic [31:0] E = 32'h3333_3333;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic br, input logic jp,
                         input logic ak, input logic [31:0] rd);
        start           = st;
        stall           = sl;
        br_taken        = br;
        jmp_req         = jp;
        u_if.imem_ack   = ak;
        u_if.imem_rdata = rd;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;

        //            st sl br jp ak rd    pw bs js rq iv by fe inst
        vecs[0]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, A,    1, 0, 0, 1, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1, 0, A};
        vecs[4]  = '{0, 0, 0, 0, 1, B,    1, 0, 0, 1, 0, 1, 0, A};
        vecs[5]  = '{0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1, 0, B};
        vecs[6]  = '{0, 1, 0, 0, 1, C,    0, 0, 0, 0, 1, 1, 0, B};
        vecs[7]  = '{0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1, 0, B};
        vecs[8]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 1, 0, B};
        vecs[9]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0, B};
        vecs[10] = '{0, 0, 0, 1, 0, 0,    0, 0, 0, 1, 0, 1, 0, B};
        vecs[11] = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0, B};
        vecs[12] = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0, B};
        vecs[13] = '{0, 0, 0, 0, 1, C,    1, 0, 1, 1, 0, 1, 0, B};
        vecs[14] = '{0, 0, 0, 0, 1, D,    1, 0, 0, 1, 0, 1, 0, B};
        vecs[15] = '{0, 1, 1, 1, 0, 0,    1, 1, 0, 0, 1, 1, 0, D};
        vecs[16] = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0, D};
        vecs[17] = '{0, 0, 0, 1, 0, 0,    0, 0, 0, 1, 0, 1, 0, D};
        vecs[18] = '{0, 0, 1, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0, D};
        vecs[19] = '{0, 0, 0, 0, 1, C,    1, 1, 0, 1, 0, 1, 0, D};
        vecs[20] = '{0, 0, 0, 1, 1, C,    1, 0, 1, 1, 0, 1, 0, D};
        vecs[21] = '{0, 0, 0, 0, 1, E,    1, 0, 0, 1, 0, 1, 0, D};
        vecs[22] = '{0, 0, 0, 1, 0, 0,    1, 0, 1, 0, 1, 1, 0, E};
        vecs[23] = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 1, 0, E};

        // Reset state
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("rst_req",   -1, {31'b0, u_if.imem_req}, 0);
        chk("rst_pw",    -1, {31'b0, pc_wr_en}, 0);
        chk("rst_iv",    -1, {31'b0, inst_valid}, 0);
        chk("rst_busy",  -1, {31'b0, busy}, 0);
        chk("rst_err",   -1, {31'b0, fetch_err}, 0);
        chk("rst_inst",  -1, inst, 0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven per-cycle vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].sl, vecs[i].br, vecs[i].jp, vecs[i].ak, vecs[i].rd);
            #1;
            chk("pc_wr_en",   i, {31'b0, pc_wr_en},      {31'b0, vecs[i].pw});
            chk("branch",     i, {31'b0, branch},        {31'b0, vecs[i].bs});
            chk("jmp",        i, {31'b0, jmp},           {31'b0, vecs[i].js});
            chk("imem_req",   i, {31'b0, u_if.imem_req}, {31'b0, vecs[i].rq});
            chk("inst_valid", i, {31'b0, inst_valid},    {31'b0, vecs[i].iv});
            chk("busy",       i, {31'b0, busy},          {31'b0, vecs[i].by});
            chk("fetch_err",  i, {31'b0, fetch_err},     {31'b0, vecs[i].fe});
            chk("inst",       i, inst,                   vecs[i].in);
        end

        // Async reset mid-REQ with a redirect pending: pending must be lost
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("areq_req",  100, {31'b0, u_if.imem_req}, 0);
        chk("areq_busy", 100, {31'b0, busy}, 0);
        chk("areq_iv",   100, {31'b0, inst_valid}, 0);
        chk("areq_inst", 100, inst, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("idle_req",  110 + i, {31'b0, u_if.imem_req}, 0);
            chk("idle_busy", 110 + i, {31'b0, busy}, 0);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 1, 0, 0, 1, A);
        #1;
        chk("post_pw",  120, {31'b0, pc_wr_en}, 1);
        chk("post_br",  120, {31'b0, branch}, 0);
        chk("post_jmp", 120, {31'b0, jmp}, 0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 32'h0);
        #1;
        chk("post_iv",   121, {31'b0, inst_valid}, 1);
        chk("post_inst", 121, inst, A);

        // Async reset mid-HOLD
        #2;
        reset = 1'b0;
        #1;
        chk("ahold_iv",   130, {31'b0, inst_valid}, 0);
        chk("ahold_inst", 130, inst, 0);
        chk("ahold_busy", 130, {31'b0, busy}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Timeout: ack never comes
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!u_if.imem_req) break;
            n++;
            chk("to_noerr", 200 + i, {31'b0, fetch_err}, 0);
            @(negedge clk);
        end
        chk("to_reqcyc", 240, n, 16);
        chk("to_err",    241, {31'b0, fetch_err}, 1);
        chk("to_req",    241, {31'b0, u_if.imem_req}, 0);
        chk("to_busy",   241, {31'b0, busy}, 0);
        @(negedge clk);
        drive(1, 0, 1, 0, 1, C);
        #1;
        chk("err_pw",  242, {31'b0, pc_wr_en}, 0);
        chk("err_br",  242, {31'b0, branch}, 0);
        chk("err_iv",  242, {31'b0, inst_valid}, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0);
        repeat (100) @(negedge clk);
        #1;
        chk("err_sticky", 243, {31'b0, fetch_err}, 1);
        chk("err_req",    243, {31'b0, u_if.imem_req}, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("err_clr", 244, {31'b0, fetch_err}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
